pim_dma: RTL



---
 rtl/pim_dma_pkg.sv | 27 ++
 rtl/pim_dma.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/pim_dma_pkg.sv
// ============================================================================
// pim_dma_pkg : shared core package - DMA state encoding and direction codes
// Revision    : 1.0
// ============================================================================
`default_nettype none

package pim_dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARB  = 3'd1,
    ST_RD   = 3'd2,
    ST_WR   = 3'd3,
    ST_DONE = 3'd4
  } dma_state_e;

  localparam logic [2:0] DMA_M2P = 3'b000;
  localparam logic [2:0] DMA_P2M = 3'b001;
  localparam int         CNT_W   = 13;

  function automatic logic dma_dir_legal(input logic [2:0] funct3);
    return (funct3 == DMA_M2P) || (funct3 == DMA_P2M);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pim_dma.sv
// ============================================================================
// pim_dma : word-by-word copy engine between data memory and a PIM bank
// Revision: 1.0
// ============================================================================
`default_nettype none

module pim_dma
  import pim_dma_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int PIM_AW = 13
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              dma_en_i,
  input  logic [2:0]        dma_funct3_i,
  input  logic [3:0]        dma_sel_pim_i,
  input  logic [CNT_W-1:0]  dma_size_i,
  input  logic [XLEN-1:0]   dma_mem_addr_i,
  output logic              dma_busy_o,
  output logic              req_dmem_o,
  input  logic              gnt_dmem_i,
  output logic [XLEN-1:0]   mem_addr_o,
  output logic [XLEN-1:0]   mem_wr_data_o,
  input  logic [XLEN-1:0]   mem_rd_data_i,
  output logic [3:0]        mem_size_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic [3:0]        pim_sel_o,
  output logic [PIM_AW-1:0] pim_addr_o,
  output logic              pim_req_o,
  output logic              pim_we_o,
  output logic [XLEN-1:0]   pim_wr_data_o,
  input  logic [XLEN-1:0]   pim_rd_data_i
);

  dma_state_e       state_q, state_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [3:0]       sel_q, sel_d;
  logic [CNT_W-1:0] size_q, size_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  base_q, base_d;
  logic [XLEN-1:0]  data_q, data_d;
  logic             rd_pend_q, rd_pend_d;

  logic             p2m;
  logic [XLEN-1:0]  word_addr;
  logic [XLEN-1:0]  src_data;
  logic [XLEN-1:0]  wr_data;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      funct3_q  <= '0;
      sel_q     <= '0;
      size_q    <= '0;
      cnt_q     <= '0;
      base_q    <= '0;
      data_q    <= '0;
      rd_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      funct3_q  <= funct3_d;
      sel_q     <= sel_d;
      size_q    <= size_d;
      cnt_q     <= cnt_d;
      base_q    <= base_d;
      data_q    <= data_d;
      rd_pend_q <= rd_pend_d;
    end
  end

  assign p2m       = (funct3_q == DMA_P2M);
  assign word_addr = base_q + (XLEN'(cnt_q) << 2);
  assign src_data  = p2m ? pim_rd_data_i : mem_rd_data_i;
  // Source data is live only the cycle after a granted read; a stalled WR uses the copy.
  assign wr_data   = rd_pend_q ? src_data : data_q;

  always_comb begin
    state_d       = state_q;
    funct3_d      = funct3_q;
    sel_d         = sel_q;
    size_d        = size_q;
    cnt_d         = cnt_q;
    base_d        = base_q;
    data_d        = rd_pend_q ? src_data : data_q;
    rd_pend_d     = 1'b0;
    req_dmem_o    = 1'b0;
    mem_addr_o    = '0;
    mem_wr_data_o = '0;
    mem_size_o    = 4'h0;
    mem_read_o    = 1'b0;
    mem_write_o   = 1'b0;
    pim_addr_o    = '0;
    pim_req_o     = 1'b0;
    pim_we_o      = 1'b0;
    pim_wr_data_o = '0;

    case (state_q)
      ST_IDLE: begin
        if (dma_en_i) begin
          if (dma_dir_legal(dma_funct3_i) && (dma_size_i != '0)) begin
            funct3_d = dma_funct3_i;
            sel_d    = dma_sel_pim_i;
            size_d   = dma_size_i;
            base_d   = dma_mem_addr_i;
            cnt_d    = '0;
            state_d  = ST_ARB;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_ARB: begin
        req_dmem_o = 1'b1;
        if (gnt_dmem_i) state_d = ST_RD;
      end
      ST_RD: begin
        req_dmem_o = 1'b1;
        if (gnt_dmem_i) begin
          rd_pend_d = 1'b1;
          if (p2m) begin
            pim_req_o  = 1'b1;
            pim_addr_o = PIM_AW'(cnt_q);
          end else begin
            mem_read_o = 1'b1;
            mem_addr_o = word_addr;
            mem_size_o = 4'hF;
          end
          state_d = ST_WR;
        end
      end
      ST_WR: begin
        req_dmem_o = 1'b1;
        if (gnt_dmem_i) begin
          if (p2m) begin
            mem_write_o   = 1'b1;
            mem_addr_o    = word_addr;
            mem_wr_data_o = wr_data;
            mem_size_o    = 4'hF;
          end else begin
            pim_req_o     = 1'b1;
            pim_we_o      = 1'b1;
            pim_addr_o    = PIM_AW'(cnt_q);
            pim_wr_data_o = wr_data;
          end
          cnt_d   = cnt_q + 1'b1;
          state_d = (cnt_q + 1'b1 == size_q) ? ST_DONE : ST_RD;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign dma_busy_o = (state_q != ST_IDLE);
  assign pim_sel_o  = sel_q;

endmodule

`default_nettype wire
